// File: rtl/data_issue_ctrl_if.sv
// Request channel between the datapath and data_issue_ctrl: valid/ready handshake carrying one operand.
interface data_issue_ctrl_if #(
    parameter int unsigned data_width = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic [data_width-1:0] req_data;

    modport master (output req_valid, output req_data, input req_ready);
    modport slave  (input req_valid, input req_data, output req_ready);
endinterface

// File: rtl/data_issue_ctrl.sv
// Credit-based issue controller ahead of a fixed-latency FU and its receiver FIFO.
// Optional simulation checks enabled by defining DATA_ISSUE_CTRL_ASSERT_EN.
module data_issue_ctrl #(
    parameter int unsigned latency    = 1,
    parameter int unsigned data_width = 32,
    parameter int unsigned credit_max = latency + 1,
    parameter int unsigned cnt_width  = $clog2(credit_max + 1)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic                  drain_req,
    output logic                  drain_done,
    data_issue_ctrl_if.slave      req,
    output logic                  op_start,
    output logic [data_width-1:0] op_data,
    input  logic                  user_enable,
    output logic [cnt_width-1:0]  credits,
    output logic [cnt_width-1:0]  outstanding,
    output logic                  busy
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam logic [cnt_width-1:0] credit_full = cnt_width'(credit_max);

    state_t                state, state_next;
    logic                  hold_valid, hold_valid_next;
    logic [data_width-1:0] hold_data, hold_data_next;
    logic                  op_start_next;
    logic [data_width-1:0] op_data_next;
    logic [cnt_width-1:0]  credits_next;
    logic                  drain_done_next;
    logic                  issue;
    logic                  accept;
    logic [cnt_width:0]    credit_sum;

    // Ready depends on registers only so accept and issue can share a cycle.
    assign req.req_ready = (state == RUN) && (!hold_valid || (credits != '0));
    assign accept        = req.req_valid && req.req_ready;
    assign issue         = (state != IDLE) && hold_valid && (credits != '0);
    assign outstanding   = credit_full - credits;
    assign busy          = (state != IDLE) || hold_valid || (outstanding != '0);

    // One extra bit so a return at full credit is visible before saturation.
    assign credit_sum = {1'b0, credits} - (cnt_width+1)'(issue) + (cnt_width+1)'(user_enable);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            hold_valid <= 1'b0;
            hold_data  <= '0;
            op_start   <= 1'b0;
            op_data    <= '0;
            credits    <= credit_full;
            drain_done <= 1'b0;
        end else begin
            state      <= state_next;
            hold_valid <= hold_valid_next;
            hold_data  <= hold_data_next;
            op_start   <= op_start_next;
            op_data    <= op_data_next;
            credits    <= credits_next;
            drain_done <= drain_done_next;
        end
    end

    always_comb begin
        state_next      = state;
        drain_done_next = 1'b0;
        hold_valid_next = hold_valid;
        hold_data_next  = hold_data;
        op_start_next   = issue;
        op_data_next    = op_data;
        credits_next    = (credit_sum > {1'b0, credit_full}) ? credit_full : credit_sum[cnt_width-1:0];

        case (state)
            IDLE:    if (enable) state_next = RUN;
            RUN:     if (drain_req) state_next = DRAIN;
            DRAIN: begin
                if (!hold_valid && (credits == credit_full) && !op_start) begin
                    state_next      = IDLE;
                    drain_done_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        if (issue) begin
            op_data_next    = hold_data;
            hold_valid_next = 1'b0;
        end
        // A same-edge handshake refills the hold register just emptied by issue.
        if (accept) begin
            hold_valid_next = 1'b1;
            hold_data_next  = req.req_data;
        end
    end

`ifdef DATA_ISSUE_CTRL_ASSERT_EN
    logic                  stall_q;
    logic [data_width-1:0] stall_data_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stall_q      <= 1'b0;
            stall_data_q <= '0;
        end else begin
            stall_q      <= req.req_valid && !req.req_ready;
            stall_data_q <= req.req_data;
            if (user_enable && (credits == credit_full)) begin
                $display("Error: data_issue_ctrl credit overflow.");
                $finish;
            end
            if (stall_q && req.req_valid && (req.req_data != stall_data_q)) begin
                $display("Error: data_issue_ctrl req_data changed while stalled.");
                $finish;
            end
        end
    end
`endif
endmodule
